// File: rtl/vec_pkg.sv
// vec_pkg: shared types and width helper for the vector magnitude datapath.
// Rev 1.0
`default_nettype none

package vec_pkg;

   typedef enum logic {
      MODE_SQ  = 1'b0,
      MODE_MAG = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      SQRT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width that holds n_ch squared width-bit signed values without overflow.
   function automatic int acc_width(input int n_ch, input int width);
      return 2 * width + $clog2(n_ch);
   endfunction

endpackage

`default_nettype wire

// File: rtl/isqrt_seq.sv
// isqrt_seq: restoring integer square root, one root bit per clock, MSB first.
// Rev 1.0
`default_nettype none

module isqrt_seq #(
   parameter int IN_W = 34
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    start,
   input  logic [IN_W-1:0]         radicand,
   output logic                    busy,
   output logic                    done,
   output logic [(IN_W+1)/2-1:0]   root
);

   localparam int ROOT_W = (IN_W + 1) / 2;
   localparam int PAD_W  = 2 * ROOT_W;
   localparam int STEP_W = ROOT_W + 3;
   localparam int CNT_W  = $clog2(ROOT_W + 1);

   logic [PAD_W-1:0]  rad_sh;
   logic [STEP_W-1:0] rem;
   logic [CNT_W-1:0]  count;

   logic              iterate;
   logic [PAD_W-1:0]  src_rad;
   logic [STEP_W-1:0] src_rem;
   logic [ROOT_W-1:0] src_root;
   logic [STEP_W-1:0] shifted;
   logic [STEP_W-1:0] trial;
   logic [STEP_W-1:0] diff;
   logic              ge;
   logic [CNT_W-1:0]  left;

   // The start cycle already performs the first step, so the final bit lands
   // ROOT_W-1 clocks after start and done follows on the next clock.
   always_comb begin
      iterate  = start | busy;
      src_rad  = start ? PAD_W'(radicand) : rad_sh;
      src_rem  = start ? '0 : rem;
      src_root = start ? '0 : root;
      shifted  = (src_rem << 2) | STEP_W'(src_rad[PAD_W-1 -: 2]);
      trial    = STEP_W'({src_root, 2'b01});
      ge       = (shifted >= trial);
      diff     = shifted - trial;
      left     = start ? CNT_W'(ROOT_W - 1) : count - 1'b1;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rad_sh <= '0;
         rem    <= '0;
         root   <= '0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (iterate) begin
            rad_sh <= src_rad << 2;
            rem    <= ge ? diff : shifted;
            root   <= (src_root << 1) | ROOT_W'(ge);
            count  <= left;
            busy   <= (left != '0);
            done   <= (left == '0);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/vector_magnitude_n.sv
// vector_magnitude_n: sequential sum-of-squares / floor-magnitude of an N-component vector.
// Rev 1.0
`default_nettype none

module vector_magnitude_n
   import vec_pkg::*;
#(
   parameter  int N_CH  = 3,
   parameter  int WIDTH = 16,
   localparam int ACC_W = acc_width(N_CH, WIDTH)
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic                    valid_in,
   input  logic [N_CH*WIDTH-1:0]   vector_in,
   input  logic                    mode_in,
   output logic                    vectors_ready,
   output logic [ACC_W-1:0]        magnitude_out,
   output logic                    valid_out,
   input  logic                    magnitude_ready
);

   localparam int ROOT_W = (ACC_W + 1) / 2;
   localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

   state_t                   state;
   mode_t                    mode_r;
   logic [N_CH*WIDTH-1:0]    vec_r;
   logic [CH_W-1:0]          ch;
   logic [ACC_W-1:0]         acc;

   logic signed [WIDTH-1:0]   ch_val;
   logic signed [2*WIDTH-1:0] sq_s;
   logic [ACC_W-1:0]          acc_next;
   logic                      last_ch;
   logic                      sqrt_start;
   logic                      sqrt_busy;
   logic                      sqrt_done;
   logic [ROOT_W-1:0]         sqrt_root;

   always_comb begin
      ch_val = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (ch == CH_W'(i)) ch_val = vec_r[i*WIDTH +: WIDTH];
      end
   end

   // A square is never negative, so the signed product zero-extends safely.
   assign sq_s       = ch_val * ch_val;
   assign acc_next   = acc + ACC_W'($unsigned(sq_s));
   assign last_ch    = (ch == CH_W'(N_CH - 1));
   assign sqrt_start = (state == ACCUM) && last_ch && (mode_r == MODE_MAG);

   isqrt_seq #(
      .IN_W (ACC_W)
   ) u_isqrt (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .start    (sqrt_start),
      .radicand (acc_next),
      .busy     (sqrt_busy),
      .done     (sqrt_done),
      .root     (sqrt_root)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= IDLE;
         mode_r        <= MODE_SQ;
         vec_r         <= '0;
         ch            <= '0;
         acc           <= '0;
         magnitude_out <= '0;
         valid_out     <= 1'b0;
         vectors_ready <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (valid_in && vectors_ready) begin
                  vec_r         <= vector_in;
                  mode_r        <= mode_t'(mode_in);
                  ch            <= '0;
                  acc           <= '0;
                  vectors_ready <= 1'b0;
                  state         <= ACCUM;
               end
            end
            ACCUM: begin
               acc <= acc_next;
               ch  <= ch + 1'b1;
               if (last_ch) begin
                  ch <= '0;
                  if (mode_r == MODE_MAG) begin
                     state <= SQRT;
                  end else begin
                     magnitude_out <= acc_next;
                     valid_out     <= 1'b1;
                     state         <= DONE;
                  end
               end
            end
            SQRT: begin
               if (sqrt_done) begin
                  magnitude_out <= ACC_W'(sqrt_root);
                  valid_out     <= 1'b1;
                  state         <= DONE;
               end else if (!sqrt_busy) begin
                  // Root unit idle without a result: drop the vector rather than stall.
                  vectors_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            DONE: begin
               if (valid_out && magnitude_ready) begin
                  valid_out     <= 1'b0;
                  vectors_ready <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: begin
               valid_out     <= 1'b0;
               vectors_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vector_magnitude_n.sv
// tb_vector_magnitude_n: table, directed and randomized checks against an arithmetic reference.
// Rev 1.0
`default_nettype none

module tb_vector_magnitude_n;

   localparam int N_CH  = 3;
   localparam int WIDTH = 16;
   localparam int ACC_W = 34;
   localparam int LAT_SQ  = 3;
   localparam int LAT_MAG = 20;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  valid_in;
   logic [N_CH*WIDTH-1:0] vector_in;
   logic                  mode_in;
   logic                  vectors_ready;
   logic [ACC_W-1:0]      magnitude_out;
   logic                  valid_out;
   logic                  magnitude_ready;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   vector_magnitude_n #(
      .N_CH  (N_CH),
      .WIDTH (WIDTH)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .valid_in        (valid_in),
      .vector_in       (vector_in),
      .mode_in         (mode_in),
      .vectors_ready   (vectors_ready),
      .magnitude_out   (magnitude_out),
      .valid_out       (valid_out),
      .magnitude_ready (magnitude_ready)
   );

   typedef struct {
      int     c0;
      int     c1;
      int     c2;
      logic   mode;
      longint exp_val;
   } vec_t;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N_CH*WIDTH-1:0] pack(input int c0, input int c1, input int c2);
      logic [WIDTH-1:0] a, b, c;
      a = WIDTH'(c0);
      b = WIDTH'(c1);
      c = WIDTH'(c2);
      return {c, b, a};
   endfunction

   function automatic longint sum_sq(input int c0, input int c1, input int c2);
      return longint'(c0) * c0 + longint'(c1) * c1 + longint'(c2) * c2;
   endfunction

   function automatic longint isqrt_ref(input longint s);
      longint lo, hi, mid;
      lo = 0;
      hi = 64'd1 << 20;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= s) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   function automatic int rnd_comp();
      case ($urandom_range(0, 4))
         0:       return -32768;
         1:       return 32767;
         2:       return 0;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   // One full transaction with magnitude_ready=1; inputs are scrambled after accept.
   task automatic run_vec(input int c0, input int c1, input int c2, input logic mode,
                          input longint exp_val, input string name);
      int lat;
      check({name, " ready"}, longint'(vectors_ready), 1);
      vector_in = pack(c0, c1, c2);
      mode_in   = mode;
      valid_in  = 1'b1;
      tick();
      valid_in  = 1'b0;
      vector_in = '1;
      mode_in   = ~mode;
      lat = 0;
      while (!valid_out && lat < 100) begin
         tick();
         lat++;
      end
      check({name, " latency"}, lat, mode ? LAT_MAG : LAT_SQ);
      check({name, " value"}, longint'(magnitude_out), exp_val);
      tick();
      check({name, " valid drop"}, longint'(valid_out), 0);
      check({name, " ready back"}, longint'(vectors_ready), 1);
      check({name, " value held"}, longint'(magnitude_out), exp_val);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      vec_t tbl[7];
      int   lat;
      int   cnt;
      logic flag;
      int   c0, c1, c2;
      logic m;
      longint s;

      tbl[0] = '{3, 4, 0, 1'b0, 25};
      tbl[1] = '{4, 9, 0, 1'b1, 9};
      tbl[2] = '{3, 4, 0, 1'b1, 5};
      tbl[3] = '{-32768, -32768, -32768, 1'b0, 64'd3221225472};
      tbl[4] = '{-32768, -32768, -32768, 1'b1, 56755};
      tbl[5] = '{0, 0, 0, 1'b1, 0};
      tbl[6] = '{32767, -1, 1, 1'b0, 64'd1073676291};

      rst             = 1'b1;
      valid_in        = 1'b0;
      vector_in       = '0;
      mode_in         = 1'b0;
      magnitude_ready = 1'b1;
      repeat (2) tick();
      check("reset ready", longint'(vectors_ready), 1);
      check("reset valid", longint'(valid_out), 0);
      check("reset value", longint'(magnitude_out), 0);
      rst = 1'b0;
      tick();
      check("post-reset ready", longint'(vectors_ready), 1);

      for (int i = 0; i < 7; i++)
         run_vec(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].mode, tbl[i].exp_val,
                 $sformatf("table%0d", i));

      // Back-to-back with valid_in held: second vector waits for IDLE.
      vector_in = pack(4, 9, 0);
      mode_in   = 1'b1;
      valid_in  = 1'b1;
      tick();
      vector_in = pack(3, 4, 0);
      lat  = 0;
      flag = 1'b1;
      while (!valid_out && lat < 100) begin
         if (vectors_ready) flag = 1'b0;
         tick();
         lat++;
      end
      check("b2b first latency", lat, LAT_MAG);
      check("b2b first value", longint'(magnitude_out), 9);
      check("b2b busy ready low", longint'(flag), 1);
      tick();
      check("b2b idle ready", longint'(vectors_ready), 1);
      tick();
      valid_in = 1'b0;
      check("b2b second accepted", longint'(vectors_ready), 0);
      lat = 0;
      while (!valid_out && lat < 100) begin
         tick();
         lat++;
      end
      check("b2b second latency", lat, LAT_MAG);
      check("b2b second value", longint'(magnitude_out), 5);
      tick();

      // Backpressure with a new vector pulsed while DONE.
      magnitude_ready = 1'b0;
      vector_in = pack(3, 4, 0);
      mode_in   = 1'b0;
      valid_in  = 1'b1;
      tick();
      valid_in = 1'b0;
      lat = 0;
      while (!valid_out && lat < 100) begin
         tick();
         lat++;
      end
      check("bp latency", lat, LAT_SQ);
      check("bp value", longint'(magnitude_out), 25);
      flag = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (i == 5) begin
            vector_in = pack(1, 1, 1);
            mode_in   = 1'b0;
            valid_in  = 1'b1;
         end
         if (i == 7) valid_in = 1'b0;
         tick();
         if (!valid_out || magnitude_out != 34'd25 || vectors_ready) flag = 1'b0;
      end
      check("bp stable", longint'(flag), 1);
      magnitude_ready = 1'b1;
      tick();
      check("bp handshake valid", longint'(valid_out), 0);
      check("bp handshake ready", longint'(vectors_ready), 1);
      cnt = 0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (valid_out) cnt++;
      end
      check("bp ignored vector", cnt, 0);

      // Asynchronous reset in the middle of the root iterations.
      vector_in = pack(3, 4, 0);
      mode_in   = 1'b1;
      valid_in  = 1'b1;
      tick();
      valid_in = 1'b0;
      repeat (8) tick();
      check("mid-sqrt busy", longint'(vectors_ready), 0);
      #2;
      rst = 1'b1;
      #1;
      check("async rst value", longint'(magnitude_out), 0);
      check("async rst ready", longint'(vectors_ready), 1);
      check("async rst valid", longint'(valid_out), 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (valid_out) cnt++;
      end
      check("no valid after rst", cnt, 0);
      run_vec(3, 4, 0, 1'b1, 5, "after rst");

      // Randomized vectors against the arithmetic reference.
      for (int i = 0; i < 30; i++) begin
         c0 = rnd_comp();
         c1 = rnd_comp();
         c2 = rnd_comp();
         m  = 1'($urandom_range(0, 1));
         s  = sum_sq(c0, c1, c2);
         run_vec(c0, c1, c2, m, m ? isqrt_ref(s) : s, $sformatf("rand%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
